// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage.
//   fetch_state_t    : fetch FSM states
//   OP/FUNCT/IMM bit : instruction field boundaries (MIPS R/I formats)
//   DEFAULT_RESET_PC : default PC loaded on reset
package fetch_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE
  } fetch_state_t;

  localparam int unsigned OP_MSB    = 31;
  localparam int unsigned OP_LSB    = 26;
  localparam int unsigned FUNCT_MSB = 5;
  localparam int unsigned IMM_MSB   = 15;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/pc_next.sv
// Combinational next-PC computation.
//   pc       in  current instruction address
//   imm16    in  branch immediate (word offset, signed)
//   branch   in  branch enable from control
//   zero     in  ALU zero flag
//   pc_plus4 out pc + 4
//   next_pc  out branch target when branch & zero, else pc + 4 (mod 2^32)
module pc_next
  import fetch_pkg::*;
(
  input  logic [31:0]      pc,
  input  logic [IMM_MSB:0] imm16,
  input  logic             branch,
  input  logic             zero,
  output logic [31:0]      pc_plus4,
  output logic [31:0]      next_pc
);

  logic [31:0] offset;

  always_comb begin
    // sign-extend and scale the word offset to bytes
    offset   = {{(31 - IMM_MSB - 2){imm16[IMM_MSB]}}, imm16, 2'b00};
    pc_plus4 = pc + 32'd4;
    next_pc  = (branch && zero) ? (pc_plus4 + offset) : pc_plus4;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage of the monocycle MIPS datapath: holds the PC, fetches one
// instruction per step over a ready handshake, exposes opcode/funct fields
// and counts retired instructions.
//   clk, rst                 clock, synchronous active-high reset
//   imem_req/addr            fetch request and address (= pc)
//   imem_ready/rdata         memory response
//   commit, branch, zero     datapath done, branch enable, ALU zero
//   instr, instr_valid       instruction register and its executing flag
//   op, funct                instr[31:26], instr[5:0]
//   pc, pc_plus4             current address and its successor
//   instr_count              retired-instruction counter (wraps)
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ready,
  input  logic [31:0]      imem_rdata,
  input  logic             commit,
  input  logic             branch,
  input  logic             zero,
  output logic [31:0]      instr,
  output logic             instr_valid,
  output logic [5:0]       op,
  output logic [5:0]       funct,
  output logic [31:0]      pc,
  output logic [31:0]      pc_plus4,
  output logic [CNT_W-1:0] instr_count
);

  fetch_state_t state;
  logic [31:0]  next_pc;

  pc_next u_pc_next (
    .pc       (pc),
    .imm16    (instr[IMM_MSB:0]),
    .branch   (branch),
    .zero     (zero),
    .pc_plus4 (pc_plus4),
    .next_pc  (next_pc)
  );

  assign imem_addr = pc;
  assign op        = instr[OP_MSB:OP_LSB];
  assign funct     = instr[FUNCT_MSB:0];

  // imem_req / instr_valid are registered alongside the state so they
  // always equal (state == S_FETCH) / (state == S_ISSUE).
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      pc          <= RESET_PC;
      instr       <= '0;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
      instr_count <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          state    <= S_FETCH;
          imem_req <= 1'b1;
        end
        S_FETCH: begin
          if (imem_ready) begin
            instr       <= imem_rdata;
            state       <= S_ISSUE;
            imem_req    <= 1'b0;
            instr_valid <= 1'b1;
          end
        end
        S_ISSUE: begin
          if (commit) begin
            pc          <= next_pc;
            instr_count <= instr_count + CNT_W'(1);
            state       <= S_FETCH;
            instr_valid <= 1'b0;
            imem_req    <= 1'b1;
          end
        end
        default: begin
          state       <= S_IDLE;
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int unsigned CW     = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          imem_req;
  logic [31:0]   imem_addr;
  logic          imem_ready;
  logic [31:0]   imem_rdata;
  logic          commit;
  logic          branch;
  logic          zero;
  logic [31:0]   instr;
  logic          instr_valid;
  logic [5:0]    op;
  logic [5:0]    funct;
  logic [31:0]   pc;
  logic [31:0]   pc_plus4;
  logic [CW-1:0] instr_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  instr_fetch_unit #(.RESET_PC(RST_PC), .CNT_W(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .commit      (commit),
    .branch      (branch),
    .zero        (zero),
    .instr       (instr),
    .instr_valid (instr_valid),
    .op          (op),
    .funct       (funct),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .instr_count (instr_count)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference next-PC from the ISA rule, plain 32-bit arithmetic.
  function automatic logic [31:0] model_next(input logic [31:0] p, input logic [31:0] ins,
                                             input bit taken);
    int off;
    logic [15:0] imm;
    imm = ins[15:0];
    off = int'($signed(imm));
    return taken ? (p + 32'd4 + 32'(off * 4)) : (p + 32'd4);
  endfunction

  typedef struct {
    bit          do_reset;
    int unsigned wait_cyc;
    logic [31:0] rdata;
    bit          br;
    bit          zr;
    logic [31:0] exp_addr;
    logic [31:0] exp_next;
  } vec_t;

  vec_t vecs[9];
  logic [31:0]   prev_instr;
  logic [CW-1:0] exp_cnt;

  task automatic run_vec(input vec_t v);
    int n;
    if (v.do_reset) begin
      rst = 1'b1;
      @(negedge clk);
      check("rst_req", imem_req, 0);
      check("rst_valid", instr_valid, 0);
      check("rst_pc", pc, RST_PC);
      check("rst_instr", instr, 0);
      check("rst_count", instr_count, 0);
      rst = 1'b0;
      exp_cnt = '0;
      prev_instr = '0;
    end
    n = 0;
    while (!imem_req && n < 8) begin
      @(negedge clk);
      n++;
    end
    check("req_seen", imem_req, 1);
    if (v.do_reset) check("req_latency", n, 1);
    check("fetch_addr", imem_addr, v.exp_addr);
    check("fetch_pc", pc, v.exp_addr);
    for (int unsigned w = 0; w < v.wait_cyc; w++) begin
      imem_ready = 1'b0;
      imem_rdata = ~v.rdata;
      commit     = 1'b1;
      @(negedge clk);
      check("wait_req", imem_req, 1);
      check("wait_addr", imem_addr, v.exp_addr);
      check("wait_valid", instr_valid, 0);
      check("wait_instr", instr, prev_instr);
      check("wait_count", instr_count, exp_cnt);
    end
    commit     = 1'b0;
    imem_ready = 1'b1;
    imem_rdata = v.rdata;
    @(negedge clk);
    imem_ready = 1'b0;
    imem_rdata = $urandom;
    check("issue_valid", instr_valid, 1);
    check("issue_req", imem_req, 0);
    check("issue_instr", instr, v.rdata);
    check("issue_op", op, v.rdata[31:26]);
    check("issue_funct", funct, v.rdata[5:0]);
    check("issue_pc4", pc_plus4, v.exp_addr + 32'd4);
    commit = 1'b1;
    branch = v.br;
    zero   = v.zr;
    @(negedge clk);
    commit = 1'b0;
    branch = 1'b0;
    zero   = 1'b0;
    exp_cnt++;
    check("commit_count", instr_count, exp_cnt);
    check("commit_valid", instr_valid, 0);
    check("commit_req", imem_req, 1);
    check("next_addr", imem_addr, v.exp_next);
    prev_instr = v.rdata;
  endtask

  // Random-phase model state
  logic [31:0]   m_pc;
  logic [31:0]   m_instr;
  logic [CW-1:0] m_cnt;
  bit            m_known;
  bit            m_idle;
  bit            m_want_req;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; imem_ready = 1'b0; imem_rdata = '0;
    commit = 1'b0; branch = 1'b0; zero = 1'b0;
    exp_cnt = '0; prev_instr = '0;

    //          rst wait rdata          br zr addr          next
    vecs[0] = '{1, 0, 32'h0000_0020, 0, 0, 32'h0000_0000, 32'h0000_0004};
    vecs[1] = '{0, 0, 32'h8C00_0004, 1, 0, 32'h0000_0004, 32'h0000_0008};
    vecs[2] = '{0, 0, 32'h1000_0003, 1, 0, 32'h0000_0008, 32'h0000_000C};
    vecs[3] = '{0, 0, 32'h1000_FFFD, 1, 1, 32'h0000_000C, 32'h0000_0004};
    vecs[4] = '{0, 0, 32'h1000_0000, 1, 1, 32'h0000_0004, 32'h0000_0008};
    vecs[5] = '{0, 3, 32'h1000_0003, 1, 1, 32'h0000_0008, 32'h0000_0018};
    vecs[6] = '{0, 1, 32'h1000_0039, 1, 1, 32'h0000_0018, 32'h0000_0100};
    vecs[7] = '{0, 0, 32'h1000_FFFF, 1, 1, 32'h0000_0100, 32'h0000_0100};
    vecs[8] = '{0, 2, 32'h1000_FFFF, 0, 1, 32'h0000_0100, 32'h0000_0104};

    @(negedge clk);
    foreach (vecs[i]) run_vec(vecs[i]);
    check("seq_count", instr_count, 9);

    // Reset while a fetch is pending, with a coincident response that must be dropped
    check("mid_req_pending", imem_req, 1);
    rst = 1'b1;
    imem_ready = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    rst = 1'b0;
    check("mid_req", imem_req, 0);
    check("mid_valid", instr_valid, 0);
    check("mid_pc", pc, RST_PC);
    check("mid_count", instr_count, 0);
    check("mid_instr", instr, 0);
    // ready stays high: idle cycle must ignore it
    @(negedge clk);
    check("late_req", imem_req, 1);
    check("late_valid", instr_valid, 0);
    check("late_addr", imem_addr, RST_PC);
    imem_rdata = 32'h0123_4567;
    @(negedge clk);
    check("tied_valid", instr_valid, 1);
    check("tied_instr", instr, 32'h0123_4567);
    imem_ready = 1'b0;
    commit = 1'b1;
    @(negedge clk);
    commit = 1'b0;
    check("tied_next", imem_addr, RST_PC + 32'd4);
    check("tied_count", instr_count, 1);

    // Randomized run against a transaction-level model
    m_known = 0; m_idle = 1; m_want_req = 0;
    m_pc = RST_PC; m_instr = '0; m_cnt = '0;
    for (int c = 0; c < 3000; c++) begin
      if (m_known) begin
        if (m_idle) begin
          check("r_idle_req", imem_req, 0);
          check("r_idle_valid", instr_valid, 0);
        end else if (m_want_req) begin
          check("r_req", imem_req, 1);
          check("r_req_valid", instr_valid, 0);
          check("r_addr", imem_addr, m_pc);
        end else begin
          check("r_valid", instr_valid, 1);
          check("r_valid_req", imem_req, 0);
          check("r_instr", instr, m_instr);
        end
        check("r_pc", pc, m_pc);
        check("r_pc4", pc_plus4, m_pc + 32'd4);
        check("r_count", instr_count, m_cnt);
        check("r_op", op, m_instr[31:26]);
        check("r_funct", funct, m_instr[5:0]);
      end
      rst        = (c == 0) || ($urandom_range(0, 199) == 0);
      imem_ready = ($urandom_range(0, 2) != 0);
      imem_rdata = $urandom;
      commit     = ($urandom_range(0, 1) == 1);
      branch     = ($urandom_range(0, 1) == 1);
      zero       = ($urandom_range(0, 1) == 1);
      if (rst) begin
        m_known = 1; m_idle = 1; m_want_req = 0;
        m_pc = RST_PC; m_instr = '0; m_cnt = '0;
      end else if (m_idle) begin
        m_idle = 0; m_want_req = 1;
      end else if (m_want_req) begin
        if (imem_ready) begin
          m_instr = imem_rdata;
          m_want_req = 0;
        end
      end else if (commit) begin
        m_pc = model_next(m_pc, m_instr, branch && zero);
        m_cnt++;
        m_want_req = 1;
      end
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
